// File: rtl/fifo_stream_reader.sv
// Read-side master for a synchronous FIFO with a one-cycle read latency.
// A 3-entry skid buffer turns FIFO reads into a valid/ready stream and counts delivered beats.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_r_en,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  beat_cnt
);

    logic [DATA_WIDTH-1:0] mem [0:2];
    logic [1:0]            rd_ptr;
    logic [1:0]            wr_ptr;
    logic [1:0]            occ;
    logic                  inflight;
    logic [2:0]            pending;
    logic                  capture;
    logic                  pop;

    function automatic logic [1:0] inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Reserving a slot for the in-flight word keeps the buffer from ever overflowing,
    // and keeps m_ready out of the read-issue path.
    assign pending   = {1'b0, occ} + {2'b0, inflight};
    assign fifo_r_en = !rst && !flush && !fifo_empty && (pending < 3'd3);

    assign capture = inflight;
    assign pop     = m_valid && m_ready;

    assign m_valid = (occ != 2'd0);
    assign m_data  = m_valid ? mem[rd_ptr] : '0;
    assign busy    = (occ != 2'd0) || inflight;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ      <= 2'd0;
            rd_ptr   <= 2'd0;
            wr_ptr   <= 2'd0;
            inflight <= 1'b0;
            beat_cnt <= '0;
        end else if (flush) begin
            occ      <= 2'd0;
            rd_ptr   <= 2'd0;
            wr_ptr   <= 2'd0;
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_r_en;
            if (capture)
                wr_ptr <= inc3(wr_ptr);
            if (pop) begin
                rd_ptr   <= inc3(rd_ptr);
                beat_cnt <= beat_cnt + 1'b1;
            end
            case ({capture, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Storage needs no reset: m_data is masked while the buffer is empty.
    always_ff @(posedge clk) begin
        if (!rst && !flush && capture)
            mem[wr_ptr] <= fifo_data_out;
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a directed vector table, then a FIFO model feeding the DUT
// with every beat checked against a queue of read-but-undelivered words tagged with arrival time.
module tb_fifo_stream_reader;
    localparam int DW = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_empty;
    logic          fifo_r_en;
    logic [DW-1:0] fifo_data_out;
    logic          flush;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          busy;
    logic [CW-1:0] beat_cnt;

    fifo_stream_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_r_en(fifo_r_en),
        .fifo_data_out(fifo_data_out), .flush(flush), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .busy(busy), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit          rst, empty, fl, rdy;
        logic [7:0]  din;
        bit          r_en, v;
        logic [7:0]  data;
        bit          bsy;
        logic [15:0] cnt;
    } vec_t;
    vec_t vecs[12];

    // Reference: FIFO contents, and words read from the FIFO but not yet delivered,
    // each with the first cycle it may appear on the stream.
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    int         exp_t[$];
    int         exp_beats;

    task automatic mreset();
        rst = 1'b1; flush = 1'b0; m_ready = 1'b0; fifo_empty = 1'b0;
        repeat (2) begin
            @(posedge clk); cyc++; #1;
        end
        fifo_q.delete(); exp_q.delete(); exp_t.delete(); exp_beats = 0;
        rst = 1'b0;
    endtask

    task automatic mcycle(input bit wen, input logic [7:0] wd, input bit rdy, input bit fl);
        bit         e_ren, e_v;
        logic [7:0] d;
        d = 8'h00;
        rst = 1'b0; m_ready = rdy; flush = fl;
        fifo_empty = (fifo_q.size() == 0);
        @(negedge clk);
        e_ren = !fl && (fifo_q.size() != 0) && (exp_q.size() < 3);
        e_v   = (exp_q.size() != 0) && (exp_t[0] <= cyc);
        chk("r_en",     32'(fifo_r_en), 32'(e_ren));
        chk("m_valid",  32'(m_valid),   32'(e_v));
        chk("m_data",   32'(m_data),    e_v ? 32'(exp_q[0]) : 32'd0);
        chk("busy",     32'(busy),      32'(exp_q.size() != 0));
        chk("beat_cnt", 32'(beat_cnt),  32'(exp_beats));
        @(posedge clk);
        if (fl) begin
            exp_q.delete(); exp_t.delete();
        end else if (e_v && rdy) begin
            void'(exp_q.pop_front()); void'(exp_t.pop_front());
            exp_beats++;
        end
        if (e_ren) begin
            d = fifo_q.pop_front();
            exp_q.push_back(d); exp_t.push_back(cyc + 2);
        end
        if (wen) fifo_q.push_back(wd);
        cyc++;
        #1 fifo_data_out = e_ren ? d : 8'($urandom);
    endtask

    initial begin
        rst = 1'b1; fifo_empty = 1'b0; flush = 1'b0; m_ready = 1'b1; fifo_data_out = 8'h00;

        // Reset held with a non-empty FIFO: nothing may be read or presented.
        @(posedge clk); cyc++; #1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rst_r_en",  32'(fifo_r_en), 32'd0);
            chk("rst_valid", 32'(m_valid),   32'd0);
            chk("rst_cnt",   32'(beat_cnt),  32'd0);
            @(posedge clk); cyc++; #1;
        end

        //          rst emp fl rdy din     r_en v  data   bsy cnt
        vecs[0]  = '{1, 0, 0, 1, 8'h00,   0, 0, 8'h00, 0, 16'd0};
        vecs[1]  = '{1, 0, 0, 1, 8'h00,   0, 0, 8'h00, 0, 16'd0};
        vecs[2]  = '{0, 0, 0, 0, 8'h11,   1, 0, 8'h00, 0, 16'd0};
        vecs[3]  = '{0, 0, 0, 0, 8'hA5,   1, 0, 8'h00, 1, 16'd0};
        vecs[4]  = '{0, 0, 0, 0, 8'h5A,   1, 1, 8'hA5, 1, 16'd0};
        vecs[5]  = '{0, 0, 0, 0, 8'hC3,   0, 1, 8'hA5, 1, 16'd0};
        vecs[6]  = '{0, 0, 0, 0, 8'hFF,   0, 1, 8'hA5, 1, 16'd0};
        vecs[7]  = '{0, 1, 0, 1, 8'hEE,   0, 1, 8'hA5, 1, 16'd0};
        vecs[8]  = '{0, 1, 0, 1, 8'hEE,   0, 1, 8'h5A, 1, 16'd1};
        vecs[9]  = '{0, 0, 0, 0, 8'hEE,   1, 1, 8'hC3, 1, 16'd2};
        vecs[10] = '{0, 0, 1, 1, 8'h77,   0, 1, 8'hC3, 1, 16'd2};
        vecs[11] = '{0, 1, 0, 1, 8'h99,   0, 0, 8'h00, 0, 16'd2};
        for (int i = 0; i < 12; i++) begin
            rst = vecs[i].rst; fifo_empty = vecs[i].empty; flush = vecs[i].fl;
            m_ready = vecs[i].rdy; fifo_data_out = vecs[i].din;
            @(negedge clk);
            chk($sformatf("vec%0d_r_en", i),  32'(fifo_r_en), 32'(vecs[i].r_en));
            chk($sformatf("vec%0d_valid", i), 32'(m_valid),   32'(vecs[i].v));
            chk($sformatf("vec%0d_data", i),  32'(m_data),    32'(vecs[i].data));
            chk($sformatf("vec%0d_busy", i),  32'(busy),      32'(vecs[i].bsy));
            chk($sformatf("vec%0d_cnt", i),   32'(beat_cnt),  32'(vecs[i].cnt));
            @(posedge clk); cyc++; #1;
        end

        // Single word.
        mreset();
        fifo_q.push_back(8'hA5);
        repeat (6) mcycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("single_cnt",  32'(beat_cnt), 32'd1);
        chk("single_busy", 32'(busy),     32'd0);

        // Continuous stream of 30 words.
        mreset();
        for (int i = 0; i < 30; i++) fifo_q.push_back(8'($urandom));
        repeat (36) mcycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("stream_cnt", 32'(beat_cnt), 32'd30);

        // Backpressure, then release.
        mreset();
        for (int i = 0; i < 10; i++) fifo_q.push_back(8'(8'h40 + i));
        repeat (10) mcycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("bp_ren",  32'(fifo_r_en), 32'd0);
        chk("bp_data", 32'(m_data),    32'h40);
        repeat (15) mcycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("bp_cnt", 32'(beat_cnt), 32'd10);

        // Writer and reader alternating.
        mreset();
        for (int i = 0; i < 60; i++) mcycle(i % 2 == 0, 8'($urandom), i % 2 == 1, 1'b0);
        repeat (10) mcycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("alt_cnt", 32'(beat_cnt), 32'd30);

        // Flush with two words buffered and one in flight.
        mreset();
        for (int i = 0; i < 10; i++) fifo_q.push_back(8'(8'h80 + i));
        repeat (3) mcycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("fl_busy_pre", 32'(busy), 32'd1);
        mcycle(1'b0, 8'h00, 1'b1, 1'b1);
        @(negedge clk);
        chk("fl_valid_after", 32'(m_valid), 32'd0);
        @(posedge clk); #1;
        cyc++;
        exp_q.delete(); exp_t.delete();
        // The extra cycle above was spent idle-reading with m_ready held high; resync the model.
        mreset();
        for (int i = 0; i < 10; i++) fifo_q.push_back(8'(8'h80 + i));
        repeat (3) mcycle(1'b0, 8'h00, 1'b0, 1'b0);
        mcycle(1'b0, 8'h00, 1'b1, 1'b1);
        repeat (15) mcycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("fl_cnt", 32'(beat_cnt), 32'd7);

        // Random traffic with occasional flushes.
        mreset();
        for (int i = 0; i < 400; i++)
            mcycle($urandom_range(1, 0) == 1, 8'($urandom), $urandom_range(9, 0) < 7,
                   $urandom_range(39, 0) == 0);
        repeat (30) mcycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("rand_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1);
    end
endmodule
